sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, meaning address width in bits.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning entry count; DEPTH SHALL equal 2**SIZE.
REQ-004 The block SHALL have parameter AF_LEVEL, default 14, meaning almost_full threshold; legal range 1..DEPTH-1.
REQ-005 The block SHALL have parameter AE_LEVEL, default 2, meaning almost_empty threshold; legal range 1..DEPTH-1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port write_en, input, 1 bit, write request.
REQ-009 The block SHALL have port read_en, input, 1 bit, read request.
REQ-010 The block SHALL have port data_in, input, WIDTH bits, write data.
REQ-011 The block SHALL have port err_clr, input, 1 bit, clears sticky error flags.
REQ-012 The block SHALL have port data_out, output, WIDTH bits, registered read data.
REQ-013 The block SHALL have port data_valid, output, 1 bit, high the cycle after an accepted read.
REQ-014 The block SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit, giving occupancy status.
REQ-015 The block SHALL have port count, output, SIZE+1 bits, current occupancy 0..DEPTH.
REQ-016 The block SHALL have ports overflow and underflow, each an output of 1 bit, sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x WIDTH array with no reset; write and read pointers SHALL be SIZE+1 bits, addressing with the low SIZE bits.
REQ-018 A write SHALL be accepted iff write_en=1 and full=0; mem[wr_ptr] takes data_in and wr_ptr increments at that edge.
REQ-019 A read SHALL be accepted iff read_en=1 and empty=0; data_out takes mem[rd_ptr] and rd_ptr increments at that edge (1-cycle latency).
REQ-020 data_valid SHALL be 1 for exactly the cycle following each accepted read and 0 otherwise; data_out SHALL hold its value when no read is accepted.
REQ-021 Pointers SHALL wrap modulo 2*DEPTH; the wrap from DEPTH-1 to 0 in the address bits SHALL toggle the pointer MSB.
REQ-022 empty SHALL be 1 iff wr_ptr==rd_ptr; full SHALL be 1 iff the MSBs differ and the low SIZE bits are equal.
REQ-023 count SHALL be +1 on write only, -1 on read only, and unchanged when both are accepted or neither is.
REQ-024 Simultaneous write and read with 0<count<DEPTH SHALL both be accepted.
REQ-025 When full, a simultaneous request SHALL accept only the read.
REQ-026 When empty, a simultaneous request SHALL accept only the write; a read of the just-written word SHALL occur no earlier than the next cycle.
REQ-027 almost_full SHALL be 1 iff count>=AF_LEVEL; almost_empty SHALL be 1 iff count<=AE_LEVEL.
REQ-028 All status outputs SHALL derive only from registered state, with no combinational path from inputs.
REQ-029 overflow SHALL set on write_en=1 while full=1; underflow SHALL set on read_en=1 while empty=1; both SHALL stay set until err_clr=1.
REQ-030 A set condition SHALL win over err_clr in the same cycle.
REQ-031 Rejected requests SHALL not modify memory, pointers or count.
REQ-032 Simulation SHALL report an error at elaboration if DEPTH!=2**SIZE or a threshold is out of range.

Reset
REQ-033 When rst_n=0, the block SHALL immediately, independent of clk, clear pointers and count, and drive data_out=0, data_valid=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0 and underflow=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries; memory contents SHALL be don't-care afterwards.
REQ-035 The first accepted request SHALL be the first rising edge with rst_n=1.

Verification
REQ-036 The bench SHALL write 16 words 0x00..0x0F from reset, then check full=1, count=16, almost_full=1 (from count 14 onward).
REQ-037 The bench SHALL read 16 words from a full FIFO and check data_out equals 0x00..0x0F in order, each with data_valid=1 one cycle after read_en, then empty=1.
REQ-038 The bench SHALL write+read at count=8 for 40 cycles, check count stays 8 and data stays ordered across pointer wrap.
REQ-039 The bench SHALL issue write_en when full and read_en when empty, check overflow=1, underflow=1, count and data unchanged; then assert err_clr and check both return to 0.
REQ-040 The bench SHALL assert rst_n=0 between clk edges at count=5, check count=0 and empty=1 immediately, then check a subsequent write/read returns the new data.

Source files
------------

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - request/response and status bundle of the synchronous FIFO
interface sync_fifo_if #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 8
);
    logic             write_en;
    logic             read_en;
    logic [WIDTH-1:0] data_in;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [SIZE:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output write_en, read_en, data_in, err_clr,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, data_in, err_clr,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data, occupancy status and sticky error flags
module sync_fifo #(
    parameter int SIZE     = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    sync_fifo_if.slave   bus
);
    if (DEPTH != 2**SIZE) begin : g_bad_depth
        $error("sync_fifo: DEPTH must equal 2**SIZE");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH-1) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > DEPTH-1) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range");
    end

    localparam logic [SIZE:0] AF_CNT = (SIZE+1)'(AF_LEVEL);
    localparam logic [SIZE:0] AE_CNT = (SIZE+1)'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SIZE:0]    r_wr_ptr;
    logic [SIZE:0]    r_rd_ptr;
    logic [SIZE:0]    r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[SIZE] != r_rd_ptr[SIZE]) &&
                      (r_wr_ptr[SIZE-1:0] == r_rd_ptr[SIZE-1:0]);
    assign w_wr_acc = bus.write_en && !w_full;
    assign w_rd_acc = bus.read_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wr_ptr[SIZE-1:0]] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_data_out <= r_mem[r_rd_ptr[SIZE-1:0]];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A fresh error condition takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.write_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (bus.read_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = r_count;
    assign bus.almost_full  = (r_count >= AF_CNT);
    assign bus.almost_empty = (r_count <= AE_CNT);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo against a queue-based reference model
module tb_sync_fifo;
    localparam int SIZE = 4, WIDTH = 8, DEPTH = 16, AF = 14, AE = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    sync_fifo #(.SIZE(SIZE), .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] exp_q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = model.size();
        chk("count", 32'(bus.count), 32'(n));
        chk("full", 32'(bus.full), 32'(n == DEPTH));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= AF));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= AE));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    // One clock of stimulus; the model decides acceptance from occupancy alone.
    task automatic cycle(input bit we, input bit re, input logic [WIDTH-1:0] din, input bit clr);
        bit acc_w, acc_r, ovf_set, unf_set;
        int n;
        n = model.size();
        acc_w   = we && (n < DEPTH);
        acc_r   = re && (n > 0);
        ovf_set = we && (n == DEPTH);
        unf_set = re && (n == 0);
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
        bus.err_clr  = clr;
        @(posedge clk);
        #1;
        if (acc_r) exp_q.push_back(model.pop_front());
        if (acc_w) model.push_back(din);
        if (ovf_set) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (unf_set) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
        chk("data_valid", 32'(bus.data_valid), 32'(acc_r));
        check_status();
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.err_clr  = 1'b0;
    endtask

    initial begin : monitor
        logic [WIDTH-1:0] last;
        last = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last = '0;
                chk("rst_data_out", 32'(bus.data_out), 32'(0));
            end else if (bus.data_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(1), 32'(0));
                end else begin
                    last = exp_q.pop_front();
                    chk("data_out", 32'(bus.data_out), 32'(last));
                end
            end else begin
                chk("data_hold", 32'(bus.data_out), 32'(last));
            end
        end
    end

    initial begin : stimulus
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = '0;
        bus.err_clr  = 1'b0;
        #1;
        check_status();
        chk("rst_data_valid", 32'(bus.data_valid), 32'(0));
        #7 rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, WIDTH'(i), 1'b0);
        chk("fill_full", 32'(bus.full), 32'(1));
        chk("fill_count", 32'(bus.count), 32'(16));
        chk("fill_af", 32'(bus.almost_full), 32'(1));

        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        chk("overflow_set", 32'(bus.overflow), 32'(1));

        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("drain_empty", 32'(bus.empty), 32'(1));

        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("underflow_set", 32'(bus.underflow), 32'(1));
        cycle(1'b0, 1'b1, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", 32'(bus.overflow), 32'(0));
        chk("unf_cleared", 32'(bus.underflow), 32'(0));

        cycle(1'b1, 1'b1, 8'h5A, 1'b0);
        while (model.size() < DEPTH) cycle(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        while (model.size() != 8) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, WIDTH'($urandom), 1'b0);

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom),
                  ($urandom_range(0, 15) == 0));

        while (model.size() != 5)
            cycle(model.size() < 5, model.size() > 5, WIDTH'($urandom), 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_status();
        chk("midrst_valid", 32'(bus.data_valid), 32'(0));
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
